// File: rtl/serial_mmio_bridge_pkg.sv
// Shared definitions for the serial MMIO bridge: register offsets, status bits
// and the transmitter handshake state encoding.
package serial_mmio_bridge_pkg;

  localparam logic [3:0] SERIAL_DATA_OFS = 4'h8;
  localparam logic [3:0] SERIAL_STAT_OFS = 4'hC;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_OVERRUN  = 2;

  // Cycles to wait for the transmitter to report busy before giving up on it
  localparam int TX_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/serial_mmio_bridge_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push into a full FIFO succeeds
// only when a pop happens in the same cycle, pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  logic [WIDTH-1:0]    mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/serial_mmio_bridge.sv
// Memory-mapped UART bridge: RX/TX FIFOs between the CPU bus and the
// async receiver/transmitter, plus the transmitter start/busy handshake.
module serial_mmio_bridge
  import serial_mmio_bridge_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_ce,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        irq
);

  localparam logic [TX_DEPTH_LOG2:0] TX_DEPTH = (TX_DEPTH_LOG2+1)'(1 << TX_DEPTH_LOG2);
  localparam logic [1:0] TX_WAIT_LAST = 2'(TX_BUSY_TIMEOUT - 1);

  logic                   rd_access, wr_access;
  logic                   rx_pop, rx_empty, rx_full, rx_drop;
  logic [7:0]             rx_dout;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic                   tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0]             tx_dout;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic                   overrun;
  tx_state_t              tx_state;
  logic [1:0]             tx_wait_cnt;

  assign rd_access = bus_ce && bus_stb && !bus_we;
  assign wr_access = bus_ce && bus_stb && bus_we;
  assign rx_pop    = rd_access && (bus_addr == SERIAL_DATA_OFS);
  // A full RX FIFO only accepts a byte when the CPU frees a slot in the same cycle
  assign rx_drop   = rx_data_ready && rx_full && !rx_pop;
  assign tx_push   = wr_access && (bus_addr == SERIAL_DATA_OFS) && (tx_count != TX_DEPTH);
  assign tx_pop    = (tx_state == TX_IDLE) && !tx_empty && !tx_busy;
  assign irq       = (rx_count != '0);

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_data_ready), .pop(rx_pop), .din(rx_data),
    .dout(rx_dout), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(bus_wdata),
    .dout(tx_dout), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  always_comb begin
    bus_rdata = '0;
    if (bus_ce && !bus_we) begin
      case (bus_addr)
        SERIAL_DATA_OFS: if (!rx_empty) bus_rdata[7:0] = rx_dout;
        SERIAL_STAT_OFS: begin
          bus_rdata[STAT_OVERRUN]  = overrun;
          bus_rdata[STAT_RX_AVAIL] = !rx_empty;
          bus_rdata[STAT_TX_READY] = !tx_full;
        end
        default: bus_rdata = '0;
      endcase
    end
  end

  // Sticky overrun; a new drop outranks a status-read clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (rx_drop) begin
      overrun <= 1'b1;
    end else if (rd_access && (bus_addr == SERIAL_STAT_OFS)) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      tx_wait_cnt <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_start <= 1'b0;
          if (tx_pop) begin
            tx_data  <= tx_dout;
            tx_start <= 1'b1;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          tx_start    <= 1'b0;
          tx_wait_cnt <= '0;
          tx_state    <= TX_WAIT_BUSY;
        end
        // A transmitter that never reports busy is treated as having sent the byte
        TX_WAIT_BUSY: begin
          if (tx_busy) begin
            tx_state <= TX_WAIT_DONE;
          end else if (tx_wait_cnt == TX_WAIT_LAST) begin
            tx_state <= TX_IDLE;
          end else begin
            tx_wait_cnt <= tx_wait_cnt + 2'd1;
          end
        end
        TX_WAIT_DONE: begin
          if (!tx_busy) tx_state <= TX_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mmio_bridge.sv
// Directed bench for serial_mmio_bridge with a simple transmitter busy model
// and a monitor that records every start pulse and busy falling edge.
module tb_serial_mmio_bridge;

  localparam logic [3:0] DATA = 4'h8;
  localparam logic [3:0] STAT = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_ce = 1'b0;
  logic        bus_stb = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [7:0]  bus_wdata = 8'h00;
  logic [31:0] bus_rdata;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        irq;

  int n_asserts = 0;
  int n_fail = 0;

  // Transmitter model: busy rises the cycle after start and lasts 10 cycles
  int   busy_hold = 0;
  logic busy_force = 1'b0;
  assign tx_busy = busy_force || (busy_hold != 0);

  int        cyc = 0;
  int        start_count = 0;
  int        fall_count = 0;
  logic [7:0] start_data [0:63];
  int        start_cyc [0:63];
  int        fall_cyc [0:63];
  logic      busy_prev = 1'b0;

  serial_mmio_bridge #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_ce(bus_ce), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .rx_data(rx_data), .rx_data_ready(rx_data_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (tx_start) busy_hold <= 10;
    else if (busy_hold != 0) busy_hold <= busy_hold - 1;
  end

  always @(negedge clk) begin
    if (tx_start && start_count < 64) begin
      start_data[start_count] = tx_data;
      start_cyc[start_count]  = cyc;
      start_count = start_count + 1;
    end
    if (busy_prev && !tx_busy && fall_count < 64) begin
      fall_cyc[fall_count] = cyc;
      fall_count = fall_count + 1;
    end
    busy_prev = tx_busy;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_ce = 1'b1; bus_stb = 1'b1; bus_we = 1'b0; bus_addr = a;
    #1 d = bus_rdata;
    @(posedge clk);
    #1 bus_ce = 1'b0; bus_stb = 1'b0;
  endtask

  task automatic bus_peek(input logic [3:0] a, input logic ce, input logic we, output logic [31:0] d);
    @(negedge clk);
    bus_ce = ce; bus_stb = 1'b0; bus_we = we; bus_addr = a;
    #1 d = bus_rdata;
    #1 bus_ce = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] v);
    @(negedge clk);
    bus_ce = 1'b1; bus_stb = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = v;
    @(posedge clk);
    #1 bus_ce = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_data_ready = 1'b1;
    @(posedge clk);
    #1 rx_data_ready = 1'b0;
  endtask

  task automatic rx_and_read(input logic [7:0] b, input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    rx_data = b; rx_data_ready = 1'b1;
    bus_ce = 1'b1; bus_stb = 1'b1; bus_we = 1'b0; bus_addr = a;
    #1 d = bus_rdata;
    @(posedge clk);
    #1 rx_data_ready = 1'b0; bus_ce = 1'b0; bus_stb = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    for (int i = 0; i < budget && start_count < target; i++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int base;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_irq", {31'b0, irq}, 32'h0);
    check_output("reset_tx_start", {31'b0, tx_start}, 32'h0);
    check_output("reset_tx_data", {24'b0, tx_data}, 32'h0);
    rst_n = 1'b1;

    bus_read(STAT, d);    check_output("reset_status", d, 32'h1);
    check_output("reset_irq_after", {31'b0, irq}, 32'h0);
    bus_read(DATA, d);    check_output("empty_data_read", d, 32'h0);
    bus_read(STAT, d);    check_output("status_after_empty_pop", d, 32'h1);
    bus_peek(STAT, 1'b0, 1'b0, d); check_output("rdata_ce_low", d, 32'h0);
    bus_peek(STAT, 1'b1, 1'b1, d); check_output("rdata_we_high", d, 32'h0);
    bus_peek(4'h4, 1'b1, 1'b0, d); check_output("rdata_other_ofs", d, 32'h0);

    // Three bytes through RX
    rx_pulse(8'h41); rx_pulse(8'h42); rx_pulse(8'h43);
    check_output("irq_after_push", {31'b0, irq}, 32'h1);
    bus_read(DATA, d); check_output("rx_pop0", d, 32'h41);
    bus_read(DATA, d); check_output("rx_pop1", d, 32'h42);
    check_output("irq_before_last_pop", {31'b0, irq}, 32'h1);
    bus_read(DATA, d); check_output("rx_pop2", d, 32'h43);
    check_output("irq_after_last_pop", {31'b0, irq}, 32'h0);
    bus_read(STAT, d); check_output("status_after_drain", d, 32'h1);

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) rx_pulse(8'(i));
    bus_peek(STAT, 1'b1, 1'b0, d); check_output("status_overrun", d, 32'h7);
    for (int i = 1; i <= 16; i++) begin
      bus_read(DATA, d); check_output("overrun_pop", d, 32'(i));
    end
    bus_peek(DATA, 1'b1, 1'b0, d); check_output("byte17_lost", d, 32'h0);
    bus_read(STAT, d); check_output("status_overrun_sticky", d, 32'h5);
    bus_read(STAT, d); check_output("status_overrun_cleared", d, 32'h1);

    // Empty FIFO with simultaneous push and pop
    rx_and_read(8'h5C, DATA, d); check_output("empty_pushpop_rdata", d, 32'h0);
    bus_peek(STAT, 1'b1, 1'b0, d); check_output("empty_pushpop_status", d, 32'h3);
    bus_read(DATA, d); check_output("empty_pushpop_byte", d, 32'h5C);
    bus_peek(STAT, 1'b1, 1'b0, d); check_output("empty_pushpop_drained", d, 32'h1);

    // Full FIFO with simultaneous push and pop: no overrun, still 16 entries
    for (int i = 0; i < 16; i++) rx_pulse(8'(8'h20 + i));
    rx_and_read(8'h99, DATA, d); check_output("full_pushpop_head", d, 32'h20);
    bus_peek(STAT, 1'b1, 1'b0, d); check_output("full_pushpop_status", d, 32'h3);
    for (int i = 1; i < 16; i++) begin
      bus_read(DATA, d); check_output("full_pushpop_pop", d, 32'(8'h20 + i));
    end
    bus_read(DATA, d); check_output("full_pushpop_last", d, 32'h99);
    bus_peek(STAT, 1'b1, 1'b0, d); check_output("full_pushpop_empty", d, 32'h1);

    // Two transmitted bytes with the busy model
    base = start_count;
    bus_write(DATA, 8'h55);
    bus_write(DATA, 8'hAA);
    wait_starts(base + 2, 100);
    check_output("tx2_start_count", 32'(start_count - base), 32'd2);
    check_output("tx2_data0", {24'b0, start_data[base]}, 32'h55);
    check_output("tx2_data1", {24'b0, start_data[base+1]}, 32'hAA);
    check_output("tx2_gap", 32'(start_cyc[base+1] - fall_cyc[fall_count-1]), 32'd2);
    repeat (20) @(negedge clk);

    // Five writes while the transmitter is held busy
    busy_force = 1'b1;
    base = start_count;
    bus_write(DATA, 8'h11); bus_write(DATA, 8'h22);
    bus_write(DATA, 8'h33);
    bus_read(STAT, d); check_output("tx_ready_3", d, 32'h1);
    bus_write(DATA, 8'h44);
    bus_read(STAT, d); check_output("tx_ready_full", d, 32'h0);
    bus_write(DATA, 8'h5A);
    check_output("tx_held_no_start", 32'(start_count - base), 32'd0);
    busy_force = 1'b0;
    wait_starts(base + 4, 200);
    repeat (30) @(negedge clk);
    check_output("tx4_start_count", 32'(start_count - base), 32'd4);
    check_output("tx4_data0", {24'b0, start_data[base]}, 32'h11);
    check_output("tx4_data1", {24'b0, start_data[base+1]}, 32'h22);
    check_output("tx4_data2", {24'b0, start_data[base+2]}, 32'h33);
    check_output("tx4_data3", {24'b0, start_data[base+3]}, 32'h44);
    bus_read(STAT, d); check_output("tx_ready_after_drain", d, 32'h1);

    // Reset in the middle of a transmission
    rx_pulse(8'hE1); rx_pulse(8'hE2);
    base = start_count;
    bus_write(DATA, 8'h77);
    bus_write(DATA, 8'h78);
    wait_starts(base + 1, 50);
    check_output("mid_first_start", 32'(start_count - base), 32'd1);
    repeat (3) @(negedge clk);
    check_output("mid_irq_before", {31'b0, irq}, 32'h1);
    check_output("mid_tx_data_before", {24'b0, tx_data}, 32'h77);
    #2 rst_n = 1'b0;
    bus_ce = 1'b1; bus_we = 1'b0; bus_stb = 1'b0; bus_addr = STAT;
    #1;
    check_output("mid_reset_irq", {31'b0, irq}, 32'h0);
    check_output("mid_reset_tx_start", {31'b0, tx_start}, 32'h0);
    check_output("mid_reset_tx_data", {24'b0, tx_data}, 32'h0);
    check_output("mid_reset_status", bus_rdata, 32'h1);
    bus_addr = DATA;
    #1 check_output("mid_reset_rx_empty", bus_rdata, 32'h0);
    bus_ce = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_output("post_reset_tx_flushed", 32'(start_count - base), 32'd1);
    bus_read(STAT, d); check_output("post_reset_status", d, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
